ram_port_controller: RTL and testbench
======================================

# ram_port_controller

Two-requester sequencer for the byte-addressed, 64-bit, big-endian RAM. It arbitrates between the instruction-fetch port (read-only) and the data port (loads and stores of 1/2/4/8 bytes). It owns the RAM's `address`/`isReading`/`dataIn` pins, and it performs read-modify-write for stores so that a store never disturbs bytes outside its size. The RAM writes while `isReading` is low, so this block holds `isReading` high except for exactly one cycle per store.

## Interface
- `ADDRESS_SIZE`, 11, RAM byte-address width.
- `MEM_WORD_SIZE`, 64, RAM word width in bits.
- `STARVE_LIMIT`, 4, maximum consecutive data grants while fetch waits.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high; sampled on the `clk` rising edge.
- `if_req`  in  1  fetch request; held with `if_addr` stable until `if_done`.
- `if_addr`  in  ADDRESS_SIZE  fetch byte address.
- `if_done`  out  1  one-cycle completion pulse.
- `if_rdata`  out  MEM_WORD_SIZE  8 bytes at `if_addr`; valid while `if_done`=1.
- `if_err`  out  1  out-of-range flag; valid while `if_done`=1.
- `d_req`  in  1  data request; all `d_*` inputs held stable until `d_done`.
- `d_we`  in  1  1 = store, 0 = load.
- `d_size`  in  2  0 = 1 byte, 1 = 2 bytes, 2 = 4 bytes, 3 = 8 bytes.
- `d_addr`  in  ADDRESS_SIZE  data byte address.
- `d_wdata`  in  MEM_WORD_SIZE  store data, right-justified.
- `d_done`  out  1  one-cycle completion pulse.
- `d_rdata`  out  MEM_WORD_SIZE  load data, zero-extended, right-justified; valid while `d_done`=1.
- `d_err`  out  1  out-of-range flag; valid while `d_done`=1.
- `ram_address`  out  ADDRESS_SIZE  to RAM `address`.
- `ram_isReading`  out  1  to RAM `isReading`.
- `ram_dataIn`  out  MEM_WORD_SIZE  to RAM `dataIn`.
- `ram_dataOut`  in  MEM_WORD_SIZE  from RAM `dataOut`.

## Operation
- States: IDLE, RD, WR, RESP.
- All `ram_*` outputs and `*_done`/`*_rdata`/`*_err` are driven from registers or decoded from the registered state only. There is no combinational path from any `*_req` input to any `ram_*` output.
- IDLE:
  - Samples `if_req` and `d_req`. Data wins, unless fetch has waited through `STARVE_LIMIT` consecutive data grants; then fetch wins.
  - The starve counter clears on a fetch grant or when `if_req`=0. It saturates at `STARVE_LIMIT`.
  - On grant, latches the winner's address, size (fetch uses size 3), `we` and `wdata`, and loads `ram_address`.
  - Range check: if addr + 8 > 2^ADDRESS_SIZE, the request goes to RESP with err=1, rdata=0, and the RAM is never written.
  - Otherwise the request goes to RD.
- RD:
  - `ram_isReading`=1 with the latched address.
  - Load: capture `ram_dataOut >> (64 − 8n)` (n = 2^size bytes) into rdata, then go to RESP.
  - Store: register merged = {wdata[8n−1:0], ram_dataOut[63−8n:0]} (n=8 means wdata in full) into `ram_dataIn`, then go to WR. Store rdata = 0.
- WR: `ram_isReading`=0 for exactly this one cycle. Address and `ram_dataIn` are unchanged. Next state is RESP.
- RESP:
  - The winner's `*_done`=1 with its rdata/err. The other port's done stays 0.
  - Next state is IDLE.
  - The requester drops `req` on the edge where it sees done. A `req` still high in IDLE is treated as a new request.
- Invariant: `ram_address` and `ram_dataIn` never change on the edge where `ram_isReading` falls, nor while it is 0.
- Reset values: state IDLE, `ram_isReading`=1, `ram_address`=0, `ram_dataIn`=0, all done/err/rdata 0, starve counter 0.

## Timing
- With `req` high in IDLE at cycle T:
  - Load or fetch: RD at T+1, done at T+2.
  - Store: RD at T+1, WR at T+2, done at T+3.
  - Range error: done at T+1.
- Back-to-back throughput: a new grant is possible in the IDLE cycle following RESP, i.e. one request per 3 cycles for reads and per 4 cycles for stores.
- Simultaneous `if_req` and `d_req` in IDLE: data is granted, unless the starve limit has been reached.
- Reset mid-operation: the state returns to IDLE at the next edge and no done pulse is emitted. Reset during WR does not undo the write: RAM contents for that store are undefined/possibly written. Reset during RD leaves the RAM unmodified.
- The non-winning requester keeps `req` high and is not acknowledged until it is granted.

## Test plan
- Fetch of preloaded bytes 0x00..0x07 at addr 0: `if_done` at T+2, `if_rdata`=0x0001020304050607, `ram_isReading` stays 1 throughout.
- Byte store 0xAB (size 0) at addr 3 over zeros, then 8-byte load at 0: `ram_isReading`=0 for exactly one cycle (T+2), `d_done` at T+3, load returns 0x000000AB00000000.
- Half load (size 1) at addr 2 of 0x0011223344556677: `d_rdata`=0x0000000000002233.
- `if_req` and `d_req` both held continuously with `STARVE_LIMIT`=4: grant order D,D,D,D,I,D,D,D,D,I.
- Load at addr 2041 (2041+8 > 2048): `d_done` at T+1, `d_err`=1, `d_rdata`=0, `ram_isReading` never 0.
- Reset asserted during the RD of a store: next cycle IDLE, `ram_isReading`=1, no `d_done`, memory unchanged.

Source files
------------

// File: rtl/ram_port_controller.sv
// Sequencer that arbitrates fetch and data requests onto one big-endian RAM.
// Ports: clk/reset, if_* fetch port, d_* data port, ram_* RAM pins.
module ram_port_controller #(
    parameter int ADDRESS_SIZE  = 11,
    parameter int MEM_WORD_SIZE = 64,
    parameter int STARVE_LIMIT  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     if_req,
    input  logic [ADDRESS_SIZE-1:0]  if_addr,
    output logic                     if_done,
    output logic [MEM_WORD_SIZE-1:0] if_rdata,
    output logic                     if_err,
    input  logic                     d_req,
    input  logic                     d_we,
    input  logic [1:0]               d_size,
    input  logic [ADDRESS_SIZE-1:0]  d_addr,
    input  logic [MEM_WORD_SIZE-1:0] d_wdata,
    output logic                     d_done,
    output logic [MEM_WORD_SIZE-1:0] d_rdata,
    output logic                     d_err,
    output logic [ADDRESS_SIZE-1:0]  ram_address,
    output logic                     ram_isReading,
    output logic [MEM_WORD_SIZE-1:0] ram_dataIn,
    input  logic [MEM_WORD_SIZE-1:0] ram_dataOut
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [ADDRESS_SIZE:0] SPAN =
        (ADDRESS_SIZE+1)'(1) << ADDRESS_SIZE;
    localparam logic [ADDRESS_SIZE:0] WBYTES =
        (ADDRESS_SIZE+1)'(MEM_WORD_SIZE / 8);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD,
        S_WR,
        S_RESP
    } state_t;

    state_t                   r_state;
    state_t                   w_next;
    logic [CW-1:0]            r_starve;
    logic                     r_fetch;
    logic [1:0]               r_size;
    logic                     r_we;
    logic [MEM_WORD_SIZE-1:0] r_wdata;
    logic [MEM_WORD_SIZE-1:0] r_rdata;
    logic                     r_err;
    logic [ADDRESS_SIZE-1:0]  r_ram_address;
    logic [MEM_WORD_SIZE-1:0] r_ram_dataIn;

    logic                     w_any;
    logic                     w_grant_if;
    logic [ADDRESS_SIZE-1:0]  w_addr;
    logic [ADDRESS_SIZE:0]    w_end;
    logic                     w_oob;
    logic [7:0]               w_nbits;
    logic [7:0]               w_shift;
    logic [MEM_WORD_SIZE-1:0] w_load;
    logic [MEM_WORD_SIZE-1:0] w_keep;
    logic [MEM_WORD_SIZE-1:0] w_merge;

    // Data normally wins; fetch wins once it has sat through the limit.
    assign w_any      = if_req || d_req;
    assign w_grant_if = if_req && (!d_req || r_starve >= CW'(STARVE_LIMIT));
    assign w_addr     = w_grant_if ? if_addr : d_addr;
    // The RAM always reads a full word, so the check uses the word size.
    assign w_end      = {1'b0, w_addr} + WBYTES;
    assign w_oob      = w_end > SPAN;

    // Big-endian: the addressed bytes sit at the top of the word.
    assign w_nbits = 8'(8) << r_size;
    assign w_shift = 8'(MEM_WORD_SIZE) - w_nbits;
    assign w_load  = ram_dataOut >> w_shift;
    assign w_keep  = {MEM_WORD_SIZE{1'b1}} >> w_nbits;
    assign w_merge = (r_wdata << w_shift) | (ram_dataOut & w_keep);

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (w_any) w_next = w_oob ? S_RESP : S_RD;
            S_RD:    w_next = r_we ? S_WR : S_RESP;
            S_WR:    w_next = S_RESP;
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_starve      <= '0;
            r_fetch       <= 1'b0;
            r_size        <= '0;
            r_we          <= 1'b0;
            r_wdata       <= '0;
            r_rdata       <= '0;
            r_err         <= 1'b0;
            r_ram_address <= '0;
            r_ram_dataIn  <= '0;
        end else begin
            r_state <= w_next;

            if (!if_req) begin
                r_starve <= '0;
            end else if (r_state == S_IDLE && w_any) begin
                if (w_grant_if)
                    r_starve <= '0;
                else if (r_starve < CW'(STARVE_LIMIT))
                    r_starve <= r_starve + 1'b1;
            end

            if (r_state == S_IDLE && w_any) begin
                r_fetch       <= w_grant_if;
                r_size        <= w_grant_if ? 2'd3 : d_size;
                r_we          <= !w_grant_if && d_we;
                r_wdata       <= d_wdata;
                r_rdata       <= '0;
                r_err         <= w_oob;
                r_ram_address <= w_addr;
            end

            if (r_state == S_RD) begin
                if (r_we) begin
                    r_ram_dataIn <= w_merge;
                    r_rdata      <= '0;
                end else begin
                    r_rdata      <= w_load;
                end
            end
        end
    end

    assign ram_address   = r_ram_address;
    assign ram_dataIn    = r_ram_dataIn;
    assign ram_isReading = (r_state != S_WR);

    assign if_done  = (r_state == S_RESP) && r_fetch;
    assign d_done   = (r_state == S_RESP) && !r_fetch;
    assign if_rdata = if_done ? r_rdata : '0;
    assign d_rdata  = d_done ? r_rdata : '0;
    assign if_err   = if_done && r_err;
    assign d_err    = d_done && r_err;

endmodule

// File: tb/tb_ram_port_controller.sv
// Directed bench for ram_port_controller with a behavioral big-endian RAM.
// Ports: none.
module tb_ram_port_controller;

    logic        clk;
    logic        reset;
    logic        if_req;
    logic [10:0] if_addr;
    logic        if_done;
    logic [63:0] if_rdata;
    logic        if_err;
    logic        d_req;
    logic        d_we;
    logic [1:0]  d_size;
    logic [10:0] d_addr;
    logic [63:0] d_wdata;
    logic        d_done;
    logic [63:0] d_rdata;
    logic        d_err;
    logic [10:0] ram_address;
    logic        ram_isReading;
    logic [63:0] ram_dataIn;
    logic [63:0] ram_dataOut;

    logic        bd_we;
    logic [10:0] bd_addr;
    logic [63:0] bd_data;
    logic [7:0]  mem [0:2047];
    int          n_low;
    int          n_chk;
    int          n_err;

    ram_port_controller dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done),
        .if_rdata(if_rdata), .if_err(if_err),
        .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_done(d_done), .d_rdata(d_rdata),
        .d_err(d_err),
        .ram_address(ram_address), .ram_isReading(ram_isReading),
        .ram_dataIn(ram_dataIn), .ram_dataOut(ram_dataOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [10:0] idx(input logic [10:0] a, input int i);
        return a + 11'(i);
    endfunction

    always_comb begin
        ram_dataOut = '0;
        for (int i = 0; i < 8; i++)
            ram_dataOut[63-8*i -: 8] = mem[idx(ram_address, i)];
    end

    always @(posedge clk) begin
        if (!ram_isReading) begin
            n_low <= n_low + 1;
            for (int i = 0; i < 8; i++)
                mem[idx(ram_address, i)] <= ram_dataIn[63-8*i -: 8];
        end else if (bd_we) begin
            for (int i = 0; i < 8; i++)
                mem[idx(bd_addr, i)] <= bd_data[63-8*i -: 8];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic bd_write(input logic [10:0] a, input logic [63:0] v);
        bd_addr = a;
        bd_data = v;
        bd_we   = 1'b1;
        @(negedge clk);
        bd_we   = 1'b0;
    endtask

    task automatic rd_op(input string tag, input logic fetch,
                         input logic [10:0] a, input logic [1:0] sz,
                         input logic [63:0] exp, input logic err);
        int low0;
        low0 = n_low;
        if (fetch) begin
            if_req = 1'b1; if_addr = a;
        end else begin
            d_req = 1'b1; d_we = 1'b0; d_size = sz; d_addr = a;
        end
        if (!err) begin
            @(negedge clk);
            chk({tag, " rd done"}, {if_done, d_done}, 2'b00);
            chk({tag, " rd addr"}, ram_address, a);
        end
        @(negedge clk);
        chk({tag, " done"}, {if_done, d_done}, fetch ? 2'b10 : 2'b01);
        chk({tag, " rdata"}, fetch ? if_rdata : d_rdata, exp);
        chk({tag, " err"}, fetch ? if_err : d_err, err);
        if_req = 1'b0;
        d_req  = 1'b0;
        @(negedge clk);
        chk({tag, " no write"}, n_low - low0, 0);
    endtask

    task automatic st_op(input string tag, input logic [10:0] a,
                         input logic [1:0] sz, input logic [63:0] wd,
                         input logic [63:0] din);
        int low0;
        low0 = n_low;
        d_req = 1'b1; d_we = 1'b1; d_size = sz; d_addr = a; d_wdata = wd;
        @(negedge clk);
        chk({tag, " rd"}, {ram_isReading, d_done}, 2'b10);
        @(negedge clk);
        chk({tag, " wr"}, {ram_isReading, d_done}, 2'b00);
        chk({tag, " wr addr"}, ram_address, a);
        chk({tag, " wr data"}, ram_dataIn, din);
        @(negedge clk);
        chk({tag, " done"}, {ram_isReading, d_done, d_err}, 3'b110);
        chk({tag, " rdata"}, d_rdata, 0);
        chk({tag, " one low"}, n_low - low0, 1);
        d_req = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        logic [9:0] got;
        logic [9:0] expv;
        int         ng;
        int         low0;
        n_chk = 0; n_err = 0; n_low = 0;
        reset = 1'b1;
        if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_size = '0; d_addr = '0; d_wdata = '0;
        bd_we = 1'b0; bd_addr = '0; bd_data = '0;
        @(negedge clk);
        bd_write(11'd0, 64'h0001020304050607);
        bd_write(11'd8, 64'h0);
        bd_write(11'd2040, 64'h8877665544332211);
        chk("reset done", {if_done, d_done, if_err, d_err}, 4'b0);
        chk("reset rd", ram_isReading, 1'b1);
        chk("reset addr", ram_address, 0);
        chk("reset din", ram_dataIn, 0);
        chk("reset rdata", if_rdata | d_rdata, 0);
        reset = 1'b0;
        @(negedge clk);

        rd_op("fetch0", 1'b1, 11'd0, 2'd3, 64'h0001020304050607, 1'b0);

        bd_write(11'd0, 64'h0);
        st_op("stb3", 11'd3, 2'd0, 64'hAB, 64'hAB00000000000000);
        rd_op("ld0a", 1'b0, 11'd0, 2'd3, 64'h000000AB00000000, 1'b0);

        bd_write(11'd0, 64'h0011223344556677);
        rd_op("ldh2", 1'b0, 11'd2, 2'd1, 64'h2233, 1'b0);
        rd_op("ldb7", 1'b0, 11'd7, 2'd0, 64'h77, 1'b0);
        rd_op("ldw4", 1'b0, 11'd4, 2'd2, 64'h44556677, 1'b0);

        st_op("stw1", 11'd1, 2'd2, 64'hDEADBEEFCAFEF00D,
              64'hCAFEF00D55667700);
        rd_op("ld0b", 1'b0, 11'd0, 2'd3, 64'h00CAFEF00D556677, 1'b0);
        st_op("sth6", 11'd6, 2'd1, 64'h1234BEEF, 64'hBEEF000000000000);
        st_op("std8", 11'd8, 2'd3, 64'h0102030405060708,
              64'h0102030405060708);
        rd_op("ld0c", 1'b0, 11'd0, 2'd3, 64'h00CAFEF00D55BEEF, 1'b0);
        rd_op("ld4", 1'b0, 11'd4, 2'd3, 64'h0D55BEEF01020304, 1'b0);

        rd_op("ld2040", 1'b0, 11'd2040, 2'd3, 64'h8877665544332211, 1'b0);
        rd_op("ld2041", 1'b0, 11'd2041, 2'd3, 64'h0, 1'b1);
        rd_op("if2041", 1'b1, 11'd2041, 2'd3, 64'h0, 1'b1);
        low0 = n_low;
        d_req = 1'b1; d_we = 1'b1; d_size = 2'd0; d_addr = 11'd2047;
        d_wdata = 64'h5A;
        @(negedge clk);
        chk("st2047 done", {d_done, d_err, ram_isReading}, 3'b111);
        d_req = 1'b0;
        @(negedge clk);
        chk("st2047 no write", n_low - low0, 0);
        rd_op("ld2040b", 1'b0, 11'd2040, 2'd3, 64'h8877665544332211, 1'b0);

        got  = '0;
        expv = 10'b1000010000;
        ng   = 0;
        if_req = 1'b1; if_addr = 11'd0;
        d_req = 1'b1; d_we = 1'b0; d_size = 2'd3; d_addr = 11'd0;
        for (int c = 0; c < 60 && ng < 10; c++) begin
            @(negedge clk);
            if (if_done || d_done) begin
                got[ng] = if_done;
                ng++;
            end
        end
        if_req = 1'b0;
        d_req  = 1'b0;
        chk("arb grants", ng, 10);
        for (int i = 0; i < 10; i++)
            chk($sformatf("arb grant %0d", i), got[i], expv[i]);
        @(negedge clk);

        low0 = n_low;
        d_req = 1'b1; d_we = 1'b1; d_size = 2'd0; d_addr = 11'd5;
        d_wdata = 64'hFF;
        @(negedge clk);
        chk("rst rd", {ram_isReading, d_done}, 2'b10);
        reset = 1'b1;
        d_req = 1'b0;
        @(negedge clk);
        chk("rst idle", {ram_isReading, d_done}, 2'b10);
        chk("rst addr", ram_address, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("rst no done", d_done, 1'b0);
        chk("rst no write", n_low - low0, 0);
        rd_op("ld0d", 1'b0, 11'd0, 2'd3, 64'h00CAFEF00D55BEEF, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
